// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fir_ctrl_pkg                                                           |
// | Shared state encoding, default taps and counter sizing helpers for the |
// | FIR coefficient sequencer.                                             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package fir_ctrl_pkg;

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] SWAP  = 2'd2;
   localparam logic [1:0] FLUSH = 2'd3;

   localparam int DEF_NUM_TAPS    = 8;
   localparam int DEF_COEFF_WIDTH = 16;

   // Tap 0 occupies the least significant slice.
   localparam logic [DEF_NUM_TAPS*DEF_COEFF_WIDTH-1:0] DEFAULT_COEFF_VEC =
      {16'h1, 16'h2, 16'h4, 16'h8, 16'h8, 16'h4, 16'h2, 16'h1};

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int inflight_width(input int max_inflight);
      return cnt_width(max_inflight);
   endfunction

   function automatic int tap_cnt_width(input int num_taps);
      return cnt_width(num_taps);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coeff_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fir_coeff_bank                                                         |
// | Shadow and active coefficient registers with a write port and a swap   |
// | strobe. FIR_COEFF_READBACK_EN adds a registered readback port.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fir_coeff_bank
   import fir_ctrl_pkg::*;
#(
   parameter int NUM_TAPS    = 8,
   parameter int COEFF_WIDTH = 16,
   parameter int ADDR_WIDTH  = $clog2(NUM_TAPS),
   parameter logic [NUM_TAPS*COEFF_WIDTH-1:0] DEFAULT_COEFF = DEFAULT_COEFF_VEC
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_en,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [COEFF_WIDTH-1:0]          wr_data,
   input  logic                            swap,
`ifdef FIR_COEFF_READBACK_EN
   input  logic [ADDR_WIDTH-1:0]           rd_addr,
   input  logic                            rd_sel,
   output logic [COEFF_WIDTH-1:0]          rd_data,
`endif
   output logic [NUM_TAPS*COEFF_WIDTH-1:0] active_flat
);

   logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] shadow;
   logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] active;

   // The swap copies the pre-edge shadow; writes are blocked during a swap.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= DEFAULT_COEFF;
         active <= DEFAULT_COEFF;
      end else begin
         if (wr_en) begin
            shadow[wr_addr] <= wr_data;
         end
         if (swap) begin
            active <= shadow;
         end
      end
   end

   assign active_flat = active;

`ifdef FIR_COEFF_READBACK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_sel ? active[rd_addr] : shadow[rd_addr];
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/fir_coeff_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fir_coeff_sequencer                                                    |
// | Stages coefficient writes and swaps them into fir_filter only with no  |
// | samples in flight, then zero-flushes and hides stale outputs.          |
// | Optional readback port: FIR_COEFF_READBACK_EN.                         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fir_coeff_sequencer
   import fir_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int COEFF_WIDTH  = 16,
   parameter int NUM_TAPS     = 8,
   parameter int OUTPUT_WIDTH = 2*DATA_WIDTH + $clog2(NUM_TAPS),
   parameter int MAX_INFLIGHT = 8,
   parameter logic [NUM_TAPS*COEFF_WIDTH-1:0] DEFAULT_COEFF = DEFAULT_COEFF_VEC
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_WIDTH-1:0]           s_data,
   input  logic                            cfg_wr_valid,
   output logic                            cfg_wr_ready,
   input  logic [$clog2(NUM_TAPS)-1:0]     cfg_wr_addr,
   input  logic [COEFF_WIDTH-1:0]          cfg_wr_data,
   input  logic                            cfg_commit,
   output logic                            cfg_busy,
   output logic [7:0]                      cfg_swap_count,
`ifdef FIR_COEFF_READBACK_EN
   input  logic [$clog2(NUM_TAPS)-1:0]     cfg_rd_addr,
   input  logic                            cfg_rd_sel,
   output logic [COEFF_WIDTH-1:0]          cfg_rd_data,
`endif
   output logic                            fir_input_valid,
   output logic [DATA_WIDTH-1:0]           fir_x,
   output logic [NUM_TAPS*COEFF_WIDTH-1:0] fir_coeff,
   input  logic                            fir_output_valid,
   input  logic [OUTPUT_WIDTH-1:0]         fir_y,
   output logic                            out_valid,
   output logic [OUTPUT_WIDTH-1:0]         out_y
);

   localparam int ADDR_WIDTH = $clog2(NUM_TAPS);
   localparam int INFL_W     = inflight_width(MAX_INFLIGHT);
   localparam int TAP_W      = tap_cnt_width(NUM_TAPS);
   localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFLIGHT);
   localparam logic [TAP_W-1:0]  TAP_N    = TAP_W'(NUM_TAPS);

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [INFL_W-1:0] inflight;
   logic [TAP_W-1:0]  flush_cnt;
   logic [TAP_W-1:0]  drop_cnt;
   logic              room;
   logic              swap_stb;
   logic              wr_en;
   logic              ret;

   assign room     = (inflight < INFL_MAX);
   assign ret      = fir_output_valid && (inflight != '0);
   assign wr_en    = cfg_wr_valid && cfg_wr_ready;
   assign cfg_busy = (state != RUN);
   assign out_y    = fir_y;
   assign out_valid = fir_output_valid && (drop_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (cfg_commit) state_next = DRAIN;
         DRAIN:   if (inflight == '0) state_next = SWAP;
         SWAP:    state_next = FLUSH;
         FLUSH:   if (flush_cnt <= TAP_W'(1)) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      s_ready         = 1'b0;
      cfg_wr_ready    = 1'b0;
      fir_input_valid = 1'b0;
      fir_x           = '0;
      swap_stb        = 1'b0;
      case (state)
         RUN: begin
            s_ready         = room;
            cfg_wr_ready    = 1'b1;
            fir_input_valid = s_valid && room;
            fir_x           = s_data;
         end
         SWAP:    swap_stb = 1'b1;
         FLUSH:   fir_input_valid = 1'b1;
         default: ;
      endcase
   end

   // Flush and drop counts are loaded together so every zero injected is hidden.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight       <= '0;
         flush_cnt      <= '0;
         drop_cnt       <= '0;
         cfg_swap_count <= '0;
      end else begin
         case ({fir_input_valid, ret})
            2'b10:   inflight <= inflight + INFL_W'(1);
            2'b01:   inflight <= inflight - INFL_W'(1);
            default: ;
         endcase
         if (swap_stb) begin
            flush_cnt      <= TAP_N;
            drop_cnt       <= TAP_N;
            cfg_swap_count <= cfg_swap_count + 8'd1;
         end else begin
            if ((state == FLUSH) && (flush_cnt != '0)) begin
               flush_cnt <= flush_cnt - TAP_W'(1);
            end
            if (fir_output_valid && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - TAP_W'(1);
            end
         end
      end
   end

   fir_coeff_bank #(
      .NUM_TAPS      (NUM_TAPS),
      .COEFF_WIDTH   (COEFF_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DEFAULT_COEFF (DEFAULT_COEFF)
   ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (cfg_wr_addr),
      .wr_data     (cfg_wr_data),
      .swap        (swap_stb),
`ifdef FIR_COEFF_READBACK_EN
      .rd_addr     (cfg_rd_addr),
      .rd_sel      (cfg_rd_sel),
      .rd_data     (cfg_rd_data),
`endif
      .active_flat (fir_coeff)
   );

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fir_coeff_sequencer                                                 |
// | Bench with an in-bench fir_filter stand-in and a sample-level model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fir_coeff_sequencer;

   localparam int DW  = 16;
   localparam int CW  = 16;
   localparam int NT  = 8;
   localparam int OW  = 2*DW + 3;
   localparam int MI  = 8;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          cfg_wr_valid = 1'b0;
   logic          cfg_wr_ready;
   logic [2:0]    cfg_wr_addr = '0;
   logic [CW-1:0] cfg_wr_data = '0;
   logic          cfg_commit = 1'b0;
   logic          cfg_busy;
   logic [7:0]    cfg_swap_count;
   logic          fir_input_valid;
   logic [DW-1:0] fir_x;
   logic [NT*CW-1:0] fir_coeff;
   logic          fir_output_valid = 1'b0;
   logic [OW-1:0] fir_y = '0;
   logic          out_valid;
   logic [OW-1:0] out_y;
   logic          stall = 1'b0;

   always #5 clk = ~clk;

   fir_coeff_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .cfg_wr_valid     (cfg_wr_valid),
      .cfg_wr_ready     (cfg_wr_ready),
      .cfg_wr_addr      (cfg_wr_addr),
      .cfg_wr_data      (cfg_wr_data),
      .cfg_commit       (cfg_commit),
      .cfg_busy         (cfg_busy),
      .cfg_swap_count   (cfg_swap_count),
      .fir_input_valid  (fir_input_valid),
      .fir_x            (fir_x),
      .fir_coeff        (fir_coeff),
      .fir_output_valid (fir_output_valid),
      .fir_y            (fir_y),
      .out_valid        (out_valid),
      .out_y            (out_y)
   );

   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     ref_swaps = 0;
   int     zeros_seen = 0;
   int     drops_seen = 0;
   longint fq_val[$];
   int     fq_stamp[$];
   longint dl[NT];
   longint ref_active[NT];
   longint ref_shadow[NT];
   longint ref_hist[$];
   longint exp_q[$];
   longint out_log[$];
   logic   nxt_fov = 1'b0;
   logic [OW-1:0] nxt_fy = '0;
   longint def_c[NT] = '{1, 2, 4, 8, 8, 4, 2, 1};
   longint ones_c[NT] = '{1, 1, 1, 1, 1, 1, 1, 1};
   longint t3_c[NT] = '{1, 1, 1, 16, 1, 1, 1, 1};

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Everything is observed on the falling edge: the values here are what the
   // next rising edge will capture. The filter stand-in's outputs update on the
   // rising edge from what was decided here.
   always @(negedge clk) begin : mon
      longint acc;
      cyc++;
      if (reset) begin
         fq_val.delete();
         fq_stamp.delete();
         exp_q.delete();
         ref_hist.delete();
         for (int k = 0; k < NT; k++) begin
            dl[k] = 0;
            ref_active[k] = def_c[k];
            ref_shadow[k] = def_c[k];
         end
         ref_swaps = 0;
         nxt_fov = 1'b0;
      end else begin
         if (out_valid) begin
            out_log.push_back(longint'(out_y));
            if (exp_q.size() == 0) check("out_spurious", 1, 0);
            else check("out_y", longint'(out_y), exp_q.pop_front());
         end
         check("s_ready", s_ready, !cfg_busy && (fq_val.size() < MI));
         check("wr_ready", cfg_wr_ready, !cfg_busy);
         if (fq_val.size() > MI) check("inflight_max", fq_val.size(), MI);
         if (cfg_busy && fir_input_valid) begin
            zeros_seen++;
            if (fir_x != '0) check("flush_x", longint'(fir_x), 0);
         end
         if (fir_output_valid && !out_valid) drops_seen++;

         // fir_filter stand-in: plain shift-register convolution, fixed latency
         if (fir_output_valid && fq_val.size() > 0) begin
            void'(fq_val.pop_front());
            void'(fq_stamp.pop_front());
         end
         if (fir_input_valid) begin
            for (int k = NT-1; k > 0; k--) dl[k] = dl[k-1];
            dl[0] = longint'(fir_x);
            acc = 0;
            for (int k = 0; k < NT; k++) acc += dl[k] * longint'(fir_coeff[k*CW +: CW]);
            fq_val.push_back(acc);
            fq_stamp.push_back(cyc);
         end

         // reference: accepted samples convolved with the bank active at acceptance
         if (s_valid && s_ready) begin
            ref_hist.push_back(longint'(s_data));
            if (ref_hist.size() > NT) void'(ref_hist.pop_front());
            acc = 0;
            for (int k = 0; k < NT; k++)
               if (k < ref_hist.size()) acc += ref_active[k] * ref_hist[ref_hist.size()-1-k];
            exp_q.push_back(acc);
         end
         if (cfg_wr_valid && cfg_wr_ready) ref_shadow[cfg_wr_addr] = longint'(cfg_wr_data);
         if (cfg_commit && !cfg_busy) begin
            ref_active = ref_shadow;
            ref_hist.delete();
            ref_swaps++;
         end

         nxt_fov = !stall && (fq_val.size() > 0) && ((cyc - fq_stamp[0]) >= LAT);
         nxt_fy  = (fq_val.size() > 0) ? OW'(fq_val[0]) : '0;
      end
   end

   always @(posedge clk) begin
      fir_output_valid <= nxt_fov;
      fir_y            <= nxt_fy;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] x);
      int n = 0;
      s_valid = 1'b1;
      s_data  = x;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", n, 0);
      step();
      s_valid = 1'b0;
   endtask

   task automatic cfg_write(input int a, input longint d);
      int n = 0;
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = 3'(a);
      cfg_wr_data  = CW'(d);
      @(negedge clk);
      while (!cfg_wr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("write_timeout", n, 0);
      step();
      cfg_wr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((cfg_busy || fq_val.size() != 0 || exp_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("idle_timeout", n, 0);
      step();
   endtask

   task automatic impulse_check(input string tag, input longint expv[NT]);
      for (int i = 0; i < NT; i++) send('0);
      wait_idle();
      out_log.delete();
      send(DW'(1));
      for (int i = 1; i < NT; i++) send('0);
      wait_idle();
      check({tag, "_count"}, out_log.size(), NT);
      for (int i = 0; i < NT && i < out_log.size(); i++)
         check($sformatf("%s_tap%0d", tag, i), out_log[i], expv[i]);
   endtask

   task automatic check_default_bank(input string tag);
      for (int k = 0; k < NT; k++)
         check($sformatf("%s_coeff%0d", tag, k), longint'(fir_coeff[k*CW +: CW]), def_c[k]);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int z0, d0, n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_s_ready", s_ready, 1);
      check("rst_wr_ready", cfg_wr_ready, 1);
      check("rst_busy", cfg_busy, 0);
      check("rst_fiv", fir_input_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_swaps", cfg_swap_count, 0);
      check_default_bank("rst");

      // 1: default impulse response
      impulse_check("t1", def_c);
      check("t1_busy", cfg_busy, 0);

      // 2: all-ones bank committed while a ramp is streaming
      for (int a = 0; a < NT; a++) cfg_write(a, 1);
      z0 = zeros_seen;
      d0 = drops_seen;
      fork
         begin
            for (int i = 0; i < 24; i++) send(DW'(i*3 + 1));
         end
         begin
            repeat (6) @(posedge clk);
            #1 cfg_commit = 1'b1;
            step();
            cfg_commit = 1'b0;
         end
      join
      wait_idle();
      check("t2_zeros", zeros_seen - z0, NT);
      check("t2_drops", drops_seen - d0, NT);
      check("t2_swaps", cfg_swap_count, 1);
      impulse_check("t2", ones_c);

      // 3: write and commit in the same cycle
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = 3'd3;
      cfg_wr_data  = 16'h10;
      cfg_commit   = 1'b1;
      step();
      cfg_wr_valid = 1'b0;
      cfg_commit   = 1'b0;
      wait_idle();
      check("t3_tap3", longint'(fir_coeff[3*CW +: CW]), 16);
      check("t3_tap2", longint'(fir_coeff[2*CW +: CW]), 1);
      check("t3_swaps", cfg_swap_count, 2);
      impulse_check("t3", t3_c);

      // 4: commits and writes while busy are ignored
      stall = 1'b1;
      for (int i = 0; i < 3; i++) send(DW'(5 + i));
      cfg_commit = 1'b1;
      step();
      for (int i = 0; i < 60; i++) begin
         if (i == 4) stall = 1'b0;
         cfg_commit   = cfg_busy;
         cfg_wr_valid = cfg_busy;
         cfg_wr_addr  = 3'd0;
         cfg_wr_data  = 16'hbeef;
         step();
      end
      cfg_commit   = 1'b0;
      cfg_wr_valid = 1'b0;
      wait_idle();
      check("t4_swaps", cfg_swap_count, 3);
      check("t4_tap0", longint'(fir_coeff[0 +: CW]), 1);

      // 5: stalled filter, backpressure at MAX_INFLIGHT, nothing lost
      out_log.delete();
      stall = 1'b1;
      fork
         begin
            for (int i = 0; i < 12; i++) send(DW'(100 + i));
         end
         begin
            repeat (20) @(negedge clk);
            check("t5_inflight", fq_val.size(), MI);
            check("t5_s_ready", s_ready, 0);
            step();
            stall = 1'b0;
         end
      join
      wait_idle();
      check("t5_outputs", out_log.size(), 12);

      // 6: reset during FLUSH
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(cfg_busy && fir_input_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("t6_flush_timeout", n, 0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_busy", cfg_busy, 0);
      check("t6_out_valid", out_valid, 0);
      check("t6_swaps", cfg_swap_count, 0);
      check("t6_s_ready", s_ready, 1);
      check_default_bank("t6");
      impulse_check("t6", def_c);

      // randomized traffic, stalls, writes and commits
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               if ($urandom_range(0, 3) == 0) step();
               send(DW'($urandom));
            end
         end
         begin
            repeat (60) begin
               stall = ($urandom_range(0, 4) == 0);
               repeat ($urandom_range(1, 6)) step();
            end
            stall = 1'b0;
         end
         begin
            repeat (25) begin
               repeat ($urandom_range(3, 20)) step();
               cfg_wr_valid = 1'b1;
               cfg_wr_addr  = 3'($urandom);
               cfg_wr_data  = CW'($urandom_range(0, 40));
               cfg_commit   = ($urandom_range(0, 3) == 0);
               step();
               cfg_wr_valid = 1'b0;
               cfg_commit   = 1'b0;
            end
         end
      join
      stall = 1'b0;
      wait_idle();
      check("rand_swaps", cfg_swap_count, longint'(8'(ref_swaps)));
      check("rand_pending", exp_q.size(), 0);
      check("rand_busy", cfg_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
